// File: rtl/rtype_seq_ctrl_pkg.sv
// Shared definitions for the R-type sequencer. This file holds the ALU op
// codes, the opcode and funct7 constants, the FSM state enum and the
// combinational instruction decoder.
package rv_rtype_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic    legal;
    alu_op_e op;
  } dec_t;

  // SLTU (funct3 011) and SRA (alt funct7, funct3 101) are deliberately
  // rejected. Illegal words still return ALU_ADD so that op is never X.
  function automatic dec_t decode(input logic [6:0] funct7,
                                  input logic [2:0] funct3,
                                  input logic [6:0] opcode);
    dec_t d;
    d.legal = 1'b0;
    d.op    = ALU_ADD;
    if (opcode == OPC_RTYPE) begin
      if (funct7 == F7_BASE) begin
        d.legal = 1'b1;
        case (funct3)
          3'b000:  d.op = ALU_ADD;
          3'b001:  d.op = ALU_SLL;
          3'b010:  d.op = ALU_SLT;
          3'b100:  d.op = ALU_XOR;
          3'b101:  d.op = ALU_SRL;
          3'b110:  d.op = ALU_OR;
          3'b111:  d.op = ALU_AND;
          default: d.legal = 1'b0;
        endcase
      end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
        d.legal = 1'b1;
        d.op    = ALU_SUB;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/rtype_seq_ctrl_if.sv
// Bus bundle for rtype_seq_ctrl. It groups the instruction stream, the
// register-file/ALU datapath control and the response stream.
//   slave  : sequencer side (consumes instructions, drives the datapath)
//   master : environment side (instruction source, RF/ALU, response sink)
interface rtype_seq_ctrl_if;
  import rv_rtype_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;

  logic [4:0]      rf_rs1;
  logic [4:0]      rf_rs2;
  logic [4:0]      rf_rd;
  logic            rf_we;
  logic [XLEN-1:0] rf_wd;
  logic [2:0]      alu_op;
  logic [XLEN-1:0] alu_result;

  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_val;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, alu_result, out_ready,
    output in_ready, rf_rs1, rf_rs2, rf_rd, rf_we, rf_wd, alu_op,
           out_valid, out_rd, out_val, out_illegal
  );

  modport master (
    output in_valid, in_instr, alu_result, out_ready,
    input  in_ready, rf_rs1, rf_rs2, rf_rd, rf_we, rf_wd, alu_op,
           out_valid, out_rd, out_val, out_illegal
  );
endinterface

// File: rtl/rtype_seq_ctrl_instr_fifo.sv
// instr_fifo: a DEPTH x W synchronous FIFO with a registered read pointer
// and no bypass, so a word pushed into an empty FIFO can be read one cycle
// later at the earliest.
//   clk, rst_n        : clock, async active-low reset (empties the FIFO)
//   i_push, i_data    : write strobe and data (ignored when full)
//   i_pop             : read strobe (ignored when empty)
//   o_data            : head entry
//   o_full, o_empty   : status flags
module instr_fifo
  import rv_rtype_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  r_wptr, r_rptr;
  logic         w_push, w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset because the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/rtype_seq_ctrl.sv
// rtype_seq_ctrl: a multi-cycle sequencer for the R-type execute datapath.
// It queues instructions and runs each one through EXEC, then WB (legal
// with rd != 0 only), then RESP. It drives the RF addresses, write port
// and ALU op, and returns one response per instruction.
//   clk, reset  : clock, async active-low reset
//   bus         : slave side of rtype_seq_ctrl_if (stream, datapath, response)
//   busy        : FSM not idle or instructions still queued
//   retired_cnt : count of response handshakes, wraps
module rtype_seq_ctrl
  import rv_rtype_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  rtype_seq_ctrl_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] retired_cnt
);
  state_e           r_state, w_next;
  logic [XLEN-1:0]  r_ir, r_res, w_head;
  logic [CNT_W-1:0] r_cnt;
  logic             w_full, w_empty, w_push, w_pop, w_hs;
  logic [4:0]       w_rd;
  dec_t             w_dec;

  assign w_push       = bus.in_valid && !w_full;
  assign bus.in_ready = !w_full;
  assign w_dec        = decode(r_ir[31:25], r_ir[14:12], r_ir[6:0]);
  assign w_rd         = r_ir[11:7];
  assign w_hs         = (r_state == ST_RESP) && bus.out_ready;
  // A retire with work queued pops straight into the next EXEC, which
  // gives the 3-cycle steady-state cadence.
  assign w_pop        = !w_empty && ((r_state == ST_IDLE) || w_hs);

  assign busy        = (r_state != ST_IDLE) || !w_empty;
  assign retired_cnt = r_cnt;

  instr_fifo #(.DEPTH(DEPTH), .W(XLEN)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (bus.in_instr),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir  <= '0;
      r_res <= '0;
      r_cnt <= '0;
    end else begin
      if (w_pop) r_ir <= w_head;
      // Illegal words latch 0 here, so the response value needs no extra mux.
      if (r_state == ST_EXEC) r_res <= w_dec.legal ? bus.alu_result : '0;
      if (w_hs) r_cnt <= r_cnt + 1'b1;
    end
  end

  // All datapath and response outputs decode from state alone. Reset
  // therefore drops rf_we at once, without waiting for a clock edge.
  always_comb begin
    w_next          = r_state;
    bus.rf_rs1      = '0;
    bus.rf_rs2      = '0;
    bus.rf_rd       = '0;
    bus.rf_we       = 1'b0;
    bus.rf_wd       = '0;
    bus.alu_op      = '0;
    bus.out_valid   = 1'b0;
    bus.out_rd      = '0;
    bus.out_val     = '0;
    bus.out_illegal = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_next = ST_EXEC;
      end
      ST_EXEC: begin
        bus.rf_rs1 = r_ir[19:15];
        bus.rf_rs2 = r_ir[24:20];
        bus.alu_op = w_dec.op;
        w_next     = (w_dec.legal && w_rd != 5'd0) ? ST_WB : ST_RESP;
      end
      ST_WB: begin
        bus.rf_we = 1'b1;
        bus.rf_rd = w_rd;
        bus.rf_wd = r_res;
        w_next    = ST_RESP;
      end
      ST_RESP: begin
        bus.out_valid   = 1'b1;
        bus.out_rd      = w_rd;
        bus.out_val     = r_res;
        bus.out_illegal = !w_dec.legal;
        if (bus.out_ready) w_next = w_empty ? ST_IDLE : ST_EXEC;
      end
      default: w_next = ST_IDLE;
    endcase
  end
endmodule
